// File: rtl/uart_reply_sequencer.sv
`timescale 1ns/1ps
// Streams one fixed reply string (optional CR/LF) per queued trigger over a
// byte valid/ready link, with a fixed idle gap between messages.
module uart_reply_sequencer #(
  parameter int                   MSG_LEN     = 4,
  parameter logic [8*MSG_LEN-1:0] MSG         = 32'h504F4C4F,
  parameter bit                   APPEND_CRLF = 1'b1,
  parameter int                   GAP_CYCLES  = 16,
  parameter int                   MAX_PENDING = 3,
  localparam int                  PW          = $clog2(MAX_PENDING+1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          trigger_i,
  input  logic          tx_ready_i,
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  output logic          busy_o,
  output logic [PW-1:0] pending_o,
  output logic          dropped_o
);
  localparam int TOTAL = MSG_LEN + (APPEND_CRLF ? 2 : 0);
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int GW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES+1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL-1);
  localparam logic [PW-1:0] MAX_P    = PW'(MAX_PENDING);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [GW-1:0] gap_q;
  logic [PW-1:0] pend_q, pend_d;
  logic          drop_q, drop_d;
  logic [7:0]    data_q;
  logic          valid_q, busy_q;
  logic          leave, accept;

  function automatic logic [7:0] msg_byte(input logic [IW-1:0] i);
    int k;
    k = int'(i);
    if (k < MSG_LEN)       return MSG[8*(MSG_LEN-1-k) +: 8];
    else if (k == MSG_LEN) return 8'h0D;
    else                   return 8'h0A;
  endfunction

  assign leave  = (state_q == IDLE) && (pend_q != '0);
  assign accept = valid_q && tx_ready_i;

  // A trigger coinciding with a message start cancels out, so it never drops.
  always_comb begin
    pend_d = pend_q;
    drop_d = 1'b0;
    if (trigger_i && !leave) begin
      if (pend_q < MAX_P) pend_d = pend_q + 1'b1;
      else                drop_d = 1'b1;
    end else if (leave && !trigger_i) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_d;
      case (state_q)
        IDLE: if (leave) begin
          state_q <= SEND;
          idx_q   <= '0;
          data_q  <= msg_byte('0);
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        SEND: if (accept) begin
          if (idx_q == LAST_IDX) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= GAP;
              gap_q   <= GAP_INIT;
            end
          end else begin
            idx_q  <= idx_q + 1'b1;
            data_q <= msg_byte(idx_q + 1'b1);
          end
        end
        GAP: if (gap_q == GW'(1)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          gap_q   <= '0;
        end else begin
          gap_q <= gap_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;
  assign busy_o     = busy_q;
  assign pending_o  = pend_q;
  assign dropped_o  = drop_q;
endmodule

// File: tb/tb_uart_reply_sequencer.sv
`timescale 1ns/1ps
// Bench for uart_reply_sequencer: instance 0 uses defaults, instance 1 has no
// CR/LF and no gap. A timing-based model predicts every output each cycle.
module tb_uart_reply_sequencer;
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n;
  logic [1:0] trig, rdy;
  logic [7:0] tx_data [2];
  logic [1:0] tx_valid, busy, dropped;
  logic [1:0] pending [2];

  uart_reply_sequencer dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .trigger_i(trig[0]), .tx_ready_i(rdy[0]),
    .tx_data_o(tx_data[0]), .tx_valid_o(tx_valid[0]), .busy_o(busy[0]),
    .pending_o(pending[0]), .dropped_o(dropped[0]));

  uart_reply_sequencer #(.APPEND_CRLF(1'b0), .GAP_CYCLES(0)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .trigger_i(trig[1]), .tx_ready_i(rdy[1]),
    .tx_data_o(tx_data[1]), .tx_valid_o(tx_valid[1]), .busy_o(busy[1]),
    .pending_o(pending[1]), .dropped_o(dropped[1]));

  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  // Model: bytes accepted so far in the current message (-1 = none in flight)
  // and the first edge at which the sequencer is idle and free to start again.
  int m_total [2] = '{6, 4};
  int m_gap   [2] = '{16, 0};
  int m_pend  [2], m_sent [2], m_free [2];
  bit m_drop  [2];
  int starts  [2] = '{0, 0};
  int drops   [2] = '{0, 0};
  int accs    [2] = '{0, 0};
  bit prev_v  [2] = '{1'b0, 1'b0};
  bit rec_on = 1'b0;
  bit vh [$];

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] polo;
    polo = 32'h504F4C4F;
    if (i < 4)  return 8'((polo >> (8*(3-i))) & 32'hFF);
    if (i == 4) return 8'h0D;
    return 8'h0A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    bit inflight, leave, acc;
    inflight = (m_sent[k] >= 0);
    leave    = !inflight && (cyc >= m_free[k]) && (m_pend[k] > 0);
    acc      = inflight && rdy[k];
    if (!rst_n) begin
      m_pend[k] = 0; m_sent[k] = -1; m_free[k] = 0; m_drop[k] = 1'b0;
    end else begin
      m_drop[k] = 1'b0;
      if (trig[k] && !leave) begin
        if (m_pend[k] < 3) m_pend[k]++;
        else               m_drop[k] = 1'b1;
      end else if (leave && !trig[k]) m_pend[k]--;
      if (acc) begin
        m_sent[k]++;
        if (m_sent[k] == m_total[k]) begin
          m_sent[k] = -1;
          m_free[k] = cyc + m_gap[k] + 1;
        end
      end
      if (leave) m_sent[k] = 0;
    end
  endtask

  task automatic tick();
    bit was_rst;
    was_rst = !rst_n;
    for (int k = 0; k < 2; k++) begin
      if (rst_n && tx_valid[k] && rdy[k]) accs[k]++;
      step(k);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("valid%0d", k), tx_valid[k], m_sent[k] >= 0);
      if (m_sent[k] >= 0) check($sformatf("data%0d", k), tx_data[k], exp_byte(m_sent[k]));
      if (was_rst) check($sformatf("rst_data%0d", k), tx_data[k], 0);
      check($sformatf("busy%0d", k), busy[k], (m_sent[k] >= 0) || (cyc + 1 < m_free[k]));
      check($sformatf("pend%0d", k), pending[k], m_pend[k]);
      check($sformatf("drop%0d", k), dropped[k], m_drop[k]);
      if (tx_valid[k] && !prev_v[k]) starts[k]++;
      prev_v[k] = tx_valid[k];
      drops[k] += int'(dropped[k]);
    end
    if (rec_on) vh.push_back(tx_valid[1]);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int n, s, d, a, first, last, ones, zeros;
    rst_n = 1'b0; trig = '0; rdy = 2'b11;
    run(2);
    rst_n = 1'b1;
    run(7);

    // 1: trigger latency and full message with gap
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    n = 1;
    while (!tx_valid[0] && n < 10) begin tick(); n++; end
    check("t1_latency", n, 2);
    check("t1_pend_cleared", pending[0], 0);
    a = accs[0];
    run(30);
    check("t1_bytes", accs[0] - a, 6);
    check("t1_idle_busy", busy[0], 0);

    // 2: backpressure while byte index 2 is offered
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    n = 0;
    while (m_sent[0] != 2 && n < 10) begin tick(); n++; end
    check("t2_reach_idx2", n < 10, 1);
    a = accs[0];
    rdy[0] = 1'b0;
    repeat (5) begin
      tick();
      check("t2_hold_data", tx_data[0], 8'h4C);
      check("t2_hold_valid", tx_valid[0], 1);
    end
    rdy[0] = 1'b1;
    run(30);
    check("t2_rest_bytes", accs[0] - a, 4);

    // 3: four triggers during a running message -> three queued, one dropped
    s = starts[0]; d = drops[0];
    trig[0] = 1'b1; tick(); trig[0] = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      trig[0] = 1'b1; tick(); trig[0] = 1'b0;
      if (i == 2) check("t3_pend_full", pending[0], 3);
      tick();
    end
    run(120);
    check("t3_msgs", starts[0] - s, 4);
    check("t3_drops", drops[0] - d, 1);

    // 4: trigger in the very cycle a queued message starts
    trig[0] = 1'b1; tick(); trig[0] = 1'b0; tick();
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    n = 0;
    while (!(m_sent[0] < 0 && cyc >= m_free[0]) && n < 40) begin tick(); n++; end
    check("t4_reach_idle", n < 40, 1);
    s = starts[0];
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    check("t4_pend", pending[0], 1);
    check("t4_drop", dropped[0], 0);
    run(60);
    check("t4_msgs", starts[0] - s, 2);

    // 5: reset while byte index 3 is offered with two messages queued
    trig[0] = 1'b1; tick(); trig[0] = 1'b0; tick();
    trig[0] = 1'b1; tick(); trig[0] = 1'b0; tick();
    trig[0] = 1'b1; tick(); trig[0] = 1'b0;
    n = 0;
    while (m_sent[0] != 3 && n < 10) begin tick(); n++; end
    check("t5_reach_idx3", n < 10, 1);
    check("t5_pend2", pending[0], 2);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t5_valid", tx_valid[0], 0);
    check("t5_busy", busy[0], 0);
    check("t5_pend", pending[0], 0);
    s = starts[0];
    run(30);
    check("t5_silent", starts[0] - s, 0);

    // 6: no CR/LF, no gap, two back-to-back triggers
    rec_on = 1'b1;
    trig[1] = 1'b1; tick(); tick(); trig[1] = 1'b0;
    run(20);
    rec_on = 1'b0;
    first = -1; last = -1; ones = 0; zeros = 0;
    foreach (vh[i]) if (vh[i]) begin
      if (first < 0) first = i;
      last = i;
      ones++;
    end
    for (int i = first; i >= 0 && i <= last; i++) if (!vh[i]) zeros++;
    check("t6_valid_cycles", ones, 8);
    check("t6_gap_cycles", zeros, 1);

    // Random traffic on both instances with rare resets
    for (int i = 0; i < 800; i++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      trig[0] = ($urandom_range(0, 7) == 0);
      trig[1] = ($urandom_range(0, 5) == 0);
      rdy[0]  = ($urandom_range(0, 9) < 7);
      rdy[1]  = ($urandom_range(0, 9) < 5);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_reply_sequencer.md
Name: uart_reply_sequencer

Overview:
Downstream of the "MARCO" match detector; sits between the match pulse and a byte-wide UART transmitter. Each match pulse queues one reply message, a parameterised constant string with optional CR/LF. Queued messages are streamed one byte at a time over a valid/ready handshake, with a fixed idle gap between messages. A saturating pending counter lets back-to-back matches queue without loss up to a limit.

Parameters:
MSG_LEN, 4, number of payload bytes in the reply string (>=1).
MSG, "POLO" packed (32'h504F4C4F), payload; byte 0 = MSG[8*MSG_LEN-1 -: 8], sent first.
APPEND_CRLF, 1, when 1 append 8'h0D then 8'h0A after the payload.
GAP_CYCLES, 16, idle clk cycles after the last byte is accepted and before the next message may start (0 allowed).
MAX_PENDING, 3, saturation limit of the queued-message counter (>=1).

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset, synchronous, active-low
trigger  in  1  single-cycle request pulse (match output)
tx_ready  in  1  downstream transmitter can accept a byte this cycle
tx_data  out  8  byte offered to the transmitter
tx_valid  out  1  tx_data is valid; a transfer occurs on any rising edge with tx_valid && tx_ready
busy  out  1  high in SEND or GAP
pending  out  PW  queued, not-yet-started messages; PW = $clog2(MAX_PENDING+1), 2 by default
dropped  out  1  one-cycle pulse when a trigger is discarded because the queue is full

Behaviour:
- Reset: all state is cleared on a clk edge with rst_n=0.
  - Outputs: tx_valid=0, tx_data=0, busy=0, pending=0, dropped=0.
  - Internal: FSM=IDLE, byte index=0, gap counter=0.
  - Reset mid-message aborts the message. No residual bytes are sent after release.
- TOTAL = MSG_LEN + 2*APPEND_CRLF. The byte index is wide enough for TOTAL-1.
- Pending counter, evaluated every cycle:
  - inc = trigger; dec = FSM leaving IDLE this cycle.
  - inc && !dec: +1 if pending<MAX_PENDING. Otherwise unchanged, and dropped=1 next cycle.
  - dec && !inc: -1. inc && dec: unchanged.
- FSM states: IDLE, SEND, GAP.
  - IDLE: tx_valid=0. If pending!=0, consume one and go to SEND with index=0.
  - Trigger latency: trigger at edge N, pending=1 after N, SEND/tx_valid=1 after edge N+1.
  - SEND: tx_valid=1, tx_data = byte[index], both registered.
  - tx_data and tx_valid are held stable until accepted. tx_valid is never dropped without a transfer, except on reset.
  - On accept with index<TOTAL-1: index+1. The next byte is presented on the following cycle, so there are no bubbles when tx_ready stays high.
  - On accept with index==TOTAL-1: tx_valid=0 next cycle. Go to GAP with counter=GAP_CYCLES, or to IDLE if GAP_CYCLES==0.
  - GAP: tx_valid=0, busy=1. Decrement each cycle; on counter==1, go to IDLE.
  - Minimum spacing between the last accept and the next first byte: GAP_CYCLES+1 cycles (one IDLE cycle).
- tx_ready is ignored whenever tx_valid=0.
- Triggers arriving in any state are queued per the counter rules. A message in flight is never restarted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. Defaults, tx_ready=1, one trigger at cycle 10 -> tx_valid rises at cycle 12. Bytes 50,4F,4C,4F,0D,0A are accepted on cycles 12–17. busy stays 1 through the 16 GAP cycles, then 0. pending returns 0 at cycle 12.
2. Backpressure: tx_ready=0 for 5 cycles while byte index 2 is offered -> tx_data holds 8'h4C and tx_valid stays 1. No byte is skipped or duplicated; the full 6-byte sequence completes.
3. Queueing: 4 triggers during an in-flight message -> pending steps to 3 and the 4th trigger gives dropped=1 for one cycle. Exactly 4 messages (1 running + 3 queued) are emitted, each separated by ≥17 idle cycles.
4. Simultaneous: pending=1 and trigger arrive in the cycle the FSM leaves IDLE -> pending stays 1, dropped=0. Two messages total follow.
5. Reset mid-message: rst_n=0 for one edge while byte index 3 is offered, with pending=2 -> next cycle tx_valid=0, busy=0, pending=0. No output after release until a new trigger.
6. APPEND_CRLF=0, GAP_CYCLES=0, two queued triggers -> exactly 4 bytes per message. There is exactly one tx_valid=0 cycle between the messages.
